// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: FSM states, opcodes,
// datapath mux selects and the per-state Moore strobe table.
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
      S_EXEC_R, S_EXEC_I, S_WB_ALU, S_BRANCH, S_JAL, S_TRAP
   } state_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_RTYPE = 2'd2, ALU_ITYPE = 2'd3} alu_op_e;
   typedef enum logic [1:0] {SRC_A_PC = 2'd0, SRC_A_OLD_PC = 2'd1, SRC_A_RS1 = 2'd2} src_a_e;
   typedef enum logic [1:0] {SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1, SRC_B_FOUR = 2'd2} src_b_e;
   typedef enum logic [1:0] {RES_ALU_OUT = 2'd0, RES_MEM_DATA = 2'd1, RES_ALU_RESULT = 2'd2} result_src_e;

   typedef struct packed {
      logic        mem_read;
      logic        mem_write;
      logic        adr_src;
      logic        pc_write;
      logic        pc_src;
      logic        branch;
      logic        reg_write;
      result_src_e result_src;
      src_a_e      alu_src_a;
      src_b_e      alu_src_b;
      alu_op_e     alu_op;
   } ctrl_t;

   // Moore strobes per state; the mem_ready-gated FETCH writes are added by the caller.
   function automatic ctrl_t state_ctrl(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRC_B_FOUR;
         end
         S_DECODE: begin
            c.alu_src_a = SRC_A_OLD_PC;
            c.alu_src_b = SRC_B_IMM;
         end
         S_MEM_ADDR: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.adr_src  = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.adr_src   = 1'b1;
         end
         S_WB_MEM: begin
            c.reg_write  = 1'b1;
            c.result_src = RES_MEM_DATA;
         end
         S_EXEC_R: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_op    = ALU_RTYPE;
         end
         S_EXEC_I: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ITYPE;
         end
         S_WB_ALU: c.reg_write = 1'b1;
         S_BRANCH: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_op    = ALU_SUB;
            c.branch    = 1'b1;
         end
         S_JAL: begin
            c.pc_write   = 1'b1;
            c.pc_src     = 1'b1;
            c.reg_write  = 1'b1;
            c.result_src = RES_ALU_RESULT;
            c.alu_src_a  = SRC_A_OLD_PC;
            c.alu_src_b  = SRC_B_FOUR;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit to datapath/memory bundle: opcode and memory handshake in, strobes out.
interface multicycle_control_unit_if #(parameter int CNT_W = 32);
   logic [6:0]       opcode;
   logic             mem_ready;
   logic             mem_read;
   logic             mem_write;
   logic             adr_src;
   logic             ir_write;
   logic             pc_write;
   logic             pc_src;
   logic             branch;
   logic             reg_write;
   logic [1:0]       result_src;
   logic [1:0]       alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             illegal;
   logic             fault;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, mem_ready,
      output mem_read, mem_write, adr_src, ir_write, pc_write, pc_src, branch,
             reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal, fault,
             instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  mem_read, mem_write, adr_src, ir_write, pc_write, pc_src, branch,
             reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal, fault,
             instr_count
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive mem_ready-low cycles in a wait state and flags the last allowed one.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   input  logic mem_ready,
   output logic expired
);
   localparam int            CW   = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

   logic [CW-1:0] count_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      count_q <= '0;
      else if (clear)                  count_q <= '0;
      else if (enable && !mem_ready)   count_q <= count_q + CW'(1);
   end

   assign expired = enable && !mem_ready && (count_q == LAST);
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: sequences each instruction and drives registered
// Moore strobes, with memory timeout, illegal-opcode trap and retire counter.
module multicycle_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter bit ENABLE_ITYPE = 1'b1,
   parameter bit ENABLE_JAL   = 1'b1,
   parameter int MEM_TIMEOUT  = 16,
   parameter int CNT_W        = 32
) (
   input logic                       clk,
   input logic                       rst_n,
   multicycle_control_unit_if.master bus
);
   state_e           state_q, next_state;
   ctrl_t            ctrl_q;
   logic             fetch_q, illegal_q, fault_q;
   logic [CNT_W-1:0] count_q;
   logic             retire, set_illegal, waiting, expired;

   assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (next_state != state_q),
      .enable    (waiting),
      .mem_ready (bus.mem_ready),
      .expired   (expired)
   );

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      next_state  = state_q;
      retire      = 1'b0;
      set_illegal = 1'b0;
      case (state_q)
         S_IDLE:   next_state = S_FETCH;
         S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
                   else if (expired)  next_state = S_TRAP;
         S_DECODE: begin
            case (bus.opcode)
               OP_LOAD, OP_STORE: next_state = S_MEM_ADDR;
               OP_R:              next_state = S_EXEC_R;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_I:              next_state = ENABLE_ITYPE ? S_EXEC_I : S_TRAP;
               OP_JAL:            next_state = ENABLE_JAL ? S_JAL : S_TRAP;
               default:           next_state = S_TRAP;
            endcase
            set_illegal = (next_state == S_TRAP);
         end
         S_MEM_ADDR: next_state = (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (bus.mem_ready) next_state = S_WB_MEM;
                     else if (expired)  next_state = S_TRAP;
         S_MEM_WR: begin
            if (bus.mem_ready) begin
               next_state = S_FETCH;
               retire     = 1'b1;
            end else if (expired) begin
               next_state = S_TRAP;
            end
         end
         S_EXEC_R, S_EXEC_I: next_state = S_WB_ALU;
         S_WB_MEM, S_WB_ALU, S_BRANCH, S_JAL: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         S_TRAP:   next_state = S_TRAP;
         default:  next_state = S_TRAP;
      endcase
   end

   // Strobes are decoded from next_state so they are registered yet aligned with state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ctrl_q    <= '0;
         fetch_q   <= 1'b0;
         illegal_q <= 1'b0;
         fault_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q <= next_state;
         ctrl_q  <= state_ctrl(next_state);
         fetch_q <= (next_state == S_FETCH);
         fault_q <= (next_state == S_TRAP);
         if (set_illegal) illegal_q <= 1'b1;
         if (retire)      count_q   <= count_q + CNT_W'(1);
      end
   end

   assign bus.mem_read    = ctrl_q.mem_read;
   assign bus.mem_write   = ctrl_q.mem_write;
   assign bus.adr_src     = ctrl_q.adr_src;
   assign bus.ir_write    = fetch_q && bus.mem_ready;
   assign bus.pc_write    = ctrl_q.pc_write || (fetch_q && bus.mem_ready);
   assign bus.pc_src      = ctrl_q.pc_src;
   assign bus.branch      = ctrl_q.branch;
   assign bus.reg_write   = ctrl_q.reg_write;
   assign bus.result_src  = ctrl_q.result_src;
   assign bus.alu_src_a   = ctrl_q.alu_src_a;
   assign bus.alu_src_b   = ctrl_q.alu_src_b;
   assign bus.alu_op      = ctrl_q.alu_op;
   assign bus.illegal     = illegal_q;
   assign bus.fault       = fault_q;
   assign bus.instr_count = count_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: dut_a (MEM_TIMEOUT=4, CNT_W=4) is checked every cycle; dut_b has
// OP-IMM and JAL disabled and shares the same stimulus.
module tb_multicycle_control_unit;

   typedef enum {T_IDLE, T_FETCH, T_DECODE, T_MEM_ADDR, T_MEM_RD, T_MEM_WR, T_WB_MEM,
                 T_EXEC_R, T_EXEC_I, T_WB_ALU, T_BRANCH, T_JAL, T_TRAP} tb_st_e;

   typedef struct {
      logic       r;
      logic [6:0] opc;
      logic       rdy;
      tb_st_e     st;
      logic       ill;
      logic       flt;
      logic [3:0] cnt;
   } vec_t;

   localparam logic [6:0] LD = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                          II = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                          BAD = 7'b0010111, NOP = 7'b0000000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] opcode = 7'h0;
   logic       mem_ready = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   vec_t       vecs[$];

   always #5 clk = ~clk;

   multicycle_control_unit_if #(.CNT_W(4))  bus_a ();
   multicycle_control_unit_if #(.CNT_W(32)) bus_b ();

   assign bus_a.opcode    = opcode;
   assign bus_a.mem_ready = mem_ready;
   assign bus_b.opcode    = opcode;
   assign bus_b.mem_ready = mem_ready;

   multicycle_control_unit #(.ENABLE_ITYPE(1'b1), .ENABLE_JAL(1'b1), .MEM_TIMEOUT(4), .CNT_W(4))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

   multicycle_control_unit #(.ENABLE_ITYPE(1'b0), .ENABLE_JAL(1'b0), .MEM_TIMEOUT(16), .CNT_W(32))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Packed as {mem_read, mem_write, adr_src, ir_write, pc_write, pc_src, branch,
   // reg_write, result_src, alu_src_a, alu_src_b, alu_op}.
   function automatic logic [15:0] exp_strobes(input tb_st_e st, input logic rdy);
      logic mr, mw, as, irw, pw, ps, br, rw;
      logic [1:0] rs, sa, sb, op;
      {mr, mw, as, irw, pw, ps, br, rw} = 8'h00;
      {rs, sa, sb, op} = 8'h00;
      case (st)
         T_FETCH:    begin mr = 1'b1; sb = 2'd2; irw = rdy; pw = rdy; end
         T_DECODE:   begin sa = 2'd1; sb = 2'd1; end
         T_MEM_ADDR: begin sa = 2'd2; sb = 2'd1; end
         T_MEM_RD:   begin mr = 1'b1; as = 1'b1; end
         T_MEM_WR:   begin mw = 1'b1; as = 1'b1; end
         T_WB_MEM:   begin rw = 1'b1; rs = 2'd1; end
         T_EXEC_R:   begin sa = 2'd2; sb = 2'd0; op = 2'd2; end
         T_EXEC_I:   begin sa = 2'd2; sb = 2'd1; op = 2'd3; end
         T_WB_ALU:   begin rw = 1'b1; rs = 2'd0; end
         T_BRANCH:   begin sa = 2'd2; sb = 2'd0; op = 2'd1; br = 1'b1; end
         T_JAL:      begin pw = 1'b1; ps = 1'b1; rw = 1'b1; rs = 2'd2; sa = 2'd1; sb = 2'd2; end
         default:    ;
      endcase
      return {mr, mw, as, irw, pw, ps, br, rw, rs, sa, sb, op};
   endfunction

   function automatic logic [15:0] strobes_a();
      return {bus_a.mem_read, bus_a.mem_write, bus_a.adr_src, bus_a.ir_write, bus_a.pc_write,
              bus_a.pc_src, bus_a.branch, bus_a.reg_write, bus_a.result_src, bus_a.alu_src_a,
              bus_a.alu_src_b, bus_a.alu_op};
   endfunction

   function automatic logic [15:0] strobes_b();
      return {bus_b.mem_read, bus_b.mem_write, bus_b.adr_src, bus_b.ir_write, bus_b.pc_write,
              bus_b.pc_src, bus_b.branch, bus_b.reg_write, bus_b.result_src, bus_b.alu_src_a,
              bus_b.alu_src_b, bus_b.alu_op};
   endfunction

   // One cycle: drive inputs on the falling edge, compare dut_a outputs 1 ns later.
   task automatic step(input logic r, input logic [6:0] opc, input logic rdy, input tb_st_e st,
                       input logic ill, input logic flt, input logic [3:0] cnt);
      @(negedge clk);
      rst_n = r; opcode = opc; mem_ready = rdy;
      #1;
      check($sformatf("%s strobes", st.name()), 32'(strobes_a()), 32'(exp_strobes(st, rdy)));
      check($sformatf("%s illegal", st.name()), 32'(bus_a.illegal), 32'(ill));
      check($sformatf("%s fault", st.name()),   32'(bus_a.fault),   32'(flt));
      check($sformatf("%s count", st.name()),   32'(bus_a.instr_count), 32'(cnt));
   endtask

   task automatic add(input logic r, input logic [6:0] opc, input logic rdy, input tb_st_e st,
                      input logic [3:0] cnt);
      vec_t v;
      v.r = r; v.opc = opc; v.rdy = rdy; v.st = st; v.ill = 1'b0; v.flt = 1'b0; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      step(1'b0, NOP, 1'b0, T_IDLE, 1'b0, 1'b0, 4'd0);
      step(1'b0, NOP, 1'b1, T_IDLE, 1'b0, 1'b0, 4'd0);
      step(1'b1, NOP, 1'b1, T_IDLE, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      // Reset held 3 cycles, then the IDLE cycle after release.
      for (int i = 0; i < 3; i++) add(1'b0, NOP, 1'b0, T_IDLE, 4'd0);
      add(1'b1, NOP, 1'b0, T_IDLE, 4'd0);
      // R-type, zero-wait.
      add(1, RR, 1, T_FETCH, 0); add(1, RR, 0, T_DECODE, 0);
      add(1, RR, 1, T_EXEC_R, 0); add(1, RR, 0, T_WB_ALU, 0);
      // I-type.
      add(1, II, 1, T_FETCH, 1); add(1, II, 1, T_DECODE, 1);
      add(1, II, 0, T_EXEC_I, 1); add(1, II, 0, T_WB_ALU, 1);
      // Load with 3 wait cycles in MEM_RD: 8 cycles total.
      add(1, LD, 1, T_FETCH, 2); add(1, LD, 0, T_DECODE, 2); add(1, LD, 0, T_MEM_ADDR, 2);
      for (int i = 0; i < 3; i++) add(1, LD, 0, T_MEM_RD, 2);
      add(1, LD, 1, T_MEM_RD, 2); add(1, LD, 0, T_WB_MEM, 2);
      // Store with one wait cycle.
      add(1, SW, 1, T_FETCH, 3); add(1, SW, 1, T_DECODE, 3); add(1, SW, 1, T_MEM_ADDR, 3);
      add(1, SW, 0, T_MEM_WR, 3); add(1, SW, 1, T_MEM_WR, 3);
      // Branch and JAL.
      add(1, BR, 1, T_FETCH, 4); add(1, BR, 0, T_DECODE, 4); add(1, BR, 1, T_BRANCH, 4);
      add(1, JL, 1, T_FETCH, 5); add(1, JL, 0, T_DECODE, 5); add(1, JL, 0, T_JAL, 5);
      // Fetch with waits, then R-type.
      add(1, RR, 0, T_FETCH, 6); add(1, RR, 0, T_FETCH, 6); add(1, RR, 1, T_FETCH, 6);
      add(1, RR, 0, T_DECODE, 6); add(1, RR, 0, T_EXEC_R, 6); add(1, RR, 0, T_WB_ALU, 6);
      // mem_ready on the 4th (timeout) fetch cycle wins.
      for (int i = 0; i < 3; i++) add(1, BR, 0, T_FETCH, 7);
      add(1, BR, 1, T_FETCH, 7); add(1, BR, 0, T_DECODE, 7); add(1, BR, 0, T_BRANCH, 7);
      add(1, NOP, 0, T_FETCH, 8);

      foreach (vecs[i]) step(vecs[i].r, vecs[i].opc, vecs[i].rdy, vecs[i].st,
                             vecs[i].ill, vecs[i].flt, vecs[i].cnt);

      // Illegal opcode: trap after DECODE, sticky for 20 cycles, nothing retired.
      do_reset();
      step(1, BAD, 1, T_FETCH, 0, 0, 0);
      step(1, BAD, 0, T_DECODE, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(1, BAD, 1'(i), T_TRAP, 1, 1, 0);
      check("dut_b illegal trap fault", 32'(bus_b.fault), 32'd1);

      // Disabled JAL / OP-IMM on dut_b trap while dut_a executes them.
      do_reset();
      step(1, JL, 1, T_FETCH, 0, 0, 0);
      step(1, JL, 0, T_DECODE, 0, 0, 0);
      step(1, JL, 0, T_JAL, 0, 0, 0);
      check("dut_b jal illegal", 32'(bus_b.illegal), 32'd1);
      check("dut_b jal fault", 32'(bus_b.fault), 32'd1);
      check("dut_b jal strobes", 32'(strobes_b()), 32'd0);
      check("dut_b jal count", bus_b.instr_count, 32'd0);
      step(1, NOP, 0, T_FETCH, 0, 0, 1);
      do_reset();
      check("dut_b reset illegal", 32'(bus_b.illegal), 32'd0);
      step(1, II, 1, T_FETCH, 0, 0, 0);
      step(1, II, 0, T_DECODE, 0, 0, 0);
      step(1, II, 0, T_EXEC_I, 0, 0, 0);
      check("dut_b itype illegal", 32'(bus_b.illegal), 32'd1);
      check("dut_b itype fault", 32'(bus_b.fault), 32'd1);

      // Fetch timeout: 4 wait cycles then TRAP with illegal clear; dut_b still waits.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, RR, 0, T_FETCH, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, RR, 0, T_TRAP, 0, 1, 0);
      check("dut_b still fetching", 32'(bus_b.mem_read), 32'd1);
      check("dut_b no fault", 32'(bus_b.fault), 32'd0);

      // Reset mid-MEM_WR with mem_ready high: strobes drop at once, no retire.
      do_reset();
      step(1, SW, 1, T_FETCH, 0, 0, 0);
      step(1, SW, 0, T_DECODE, 0, 0, 0);
      step(1, SW, 0, T_MEM_ADDR, 0, 0, 0);
      step(1, SW, 1, T_MEM_WR, 0, 0, 0);
      #1 rst_n = 1'b0;
      #1;
      check("abort mem_write", 32'(bus_a.mem_write), 32'd0);
      check("abort strobes", 32'(strobes_a()), 32'd0);
      check("abort count", 32'(bus_a.instr_count), 32'd0);
      step(1, NOP, 0, T_IDLE, 0, 0, 0);
      step(1, NOP, 0, T_FETCH, 0, 0, 0);

      // 16 branches retire: 4-bit counter wraps to 0.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1, BR, 1, T_FETCH, 0, 0, 4'(i));
         step(1, BR, 0, T_DECODE, 0, 0, 4'(i));
         step(1, BR, 0, T_BRANCH, 0, 0, 4'(i));
      end
      step(1, NOP, 0, T_FETCH, 0, 0, 4'd0);
      check("dut_b wrap count", bus_b.instr_count, 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
